// File: rtl/bitserial_exec_ctrl_pkg.sv
// cpu_pkg: shared definitions for the bit-serial CPU execution sequencer.
//   - opcode values OP_NOP..OP_OUT (0xA-0xF are undefined)
//   - ALU function encodings (alu_op_e)
//   - sequencer state encoding (state_e)
//   - default datapath width and bit-counter width
package cpu_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 3;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_LDI = 4'h6;
  localparam logic [3:0] OP_SHL = 4'h7;
  localparam logic [3:0] OP_SHR = 4'h8;
  localparam logic [3:0] OP_OUT = 4'h9;

  // ADD sits at code 0 so that "don't care" ALU selections (NOP, OUT,
  // undefined opcodes, idle) all present as zero on alu_op.
  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_PASSB = 3'd5,
    ALU_SHL   = 3'd6,
    ALU_SHR   = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_WB    = 2'd3
  } state_e;

endpackage

// File: rtl/bitserial_exec_ctrl_decode.sv
// exec_decode: combinational opcode decoder for the execution sequencer.
// Ports:
//   opcode     in  4  latched instruction opcode
//   shamt      in  4  latched shift amount (pass count for SHL/SHR)
//   alu_op     out 3  ALU function for the whole instruction
//   passes     out 4  number of WIDTH-cycle serial passes
//   carry_init out 1  initial carry/borrow loaded on the first bit
//   wb_acc     out 1  instruction writes the accumulator
//   wb_out     out 1  instruction latches the accumulator to the output
//   illegal    out 1  opcode is undefined (executed as NOP)
module exec_decode
  import cpu_pkg::*;
(
  input  logic [3:0] opcode,
  input  logic [3:0] shamt,
  output alu_op_e    alu_op,
  output logic [3:0] passes,
  output logic       carry_init,
  output logic       wb_acc,
  output logic       wb_out,
  output logic       illegal
);

  always_comb begin
    alu_op     = ALU_ADD;
    passes     = 4'd0;
    carry_init = 1'b0;
    wb_acc     = 1'b0;
    wb_out     = 1'b0;
    illegal    = 1'b0;
    case (opcode)
      OP_NOP: ;
      OP_ADD: begin alu_op = ALU_ADD;   passes = 4'd1; wb_acc = 1'b1; end
      // Subtraction is a + ~b + 1: the ALU inverts b, the +1 comes from here.
      OP_SUB: begin alu_op = ALU_SUB;   passes = 4'd1; wb_acc = 1'b1; carry_init = 1'b1; end
      OP_AND: begin alu_op = ALU_AND;   passes = 4'd1; wb_acc = 1'b1; end
      OP_OR:  begin alu_op = ALU_OR;    passes = 4'd1; wb_acc = 1'b1; end
      OP_XOR: begin alu_op = ALU_XOR;   passes = 4'd1; wb_acc = 1'b1; end
      OP_LDI: begin alu_op = ALU_PASSB; passes = 4'd1; wb_acc = 1'b1; end
      // One pass per bit position shifted; shamt is deliberately not clamped.
      OP_SHL: begin alu_op = ALU_SHL;   passes = shamt; wb_acc = 1'b1; end
      OP_SHR: begin alu_op = ALU_SHR;   passes = shamt; wb_acc = 1'b1; end
      OP_OUT: begin wb_out = 1'b1; end
      default: begin illegal = 1'b1; end
    endcase
  end

endmodule

// File: rtl/bitserial_exec_ctrl.sv
// bitserial_exec_ctrl: execution sequencer for the 8-bit bit-serial CPU.
// Latches an instruction on a start pulse, then walks LOAD -> SHIFT (passes x
// WIDTH cycles, LSB first) -> WB, driving the serial datapath strobes.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   start            one-cycle pulse, opcode/instr valid
//   opcode, instr    instruction; instr[11:4] immediate, instr[3:0] shamt
//   busy             high in LOAD, SHIFT and WB
//   done             one-cycle pulse in WB
//   op_load          parallel-load the operand shift register
//   operand          latched instr[11:4]
//   shift_en         advance shift registers and ALU carry flop
//   bit_idx          current serial bit (0 = LSB)
//   first_bit        first bit of a pass (ALU loads carry_init)
//   last_bit         last bit of a pass
//   carry_init       initial carry/borrow, valid while busy
//   alu_op           ALU function, valid while busy
//   acc_we, out_we   writeback strobes (WB only)
//   illegal          undefined-opcode pulse alongside done
//   overrun          sticky: start seen while not idle
module bitserial_exec_ctrl
  import cpu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic [11:0]      instr,
  output logic             busy,
  output logic             done,
  output logic             op_load,
  output logic [7:0]       operand,
  output logic             shift_en,
  output logic [CNT_W-1:0] bit_idx,
  output logic             first_bit,
  output logic             last_bit,
  output logic             carry_init,
  output logic [2:0]       alu_op,
  output logic             acc_we,
  output logic             out_we,
  output logic             illegal,
  output logic             overrun
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           r_state;
  state_e           w_next_state;
  logic [3:0]       r_opcode;
  logic [3:0]       r_shamt;
  logic [7:0]       r_operand;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [3:0]       r_pass_cnt;
  logic             r_overrun;

  alu_op_e          w_alu_op;
  logic [3:0]       w_passes;
  logic             w_carry_init;
  logic             w_wb_acc;
  logic             w_wb_out;
  logic             w_illegal;
  logic             w_last_pass_bit;

  // Decoding the latched copies keeps every control output a function of
  // registered state only; the live opcode/instr inputs may change mid-flight.
  exec_decode u_decode (
    .opcode     (r_opcode),
    .shamt      (r_shamt),
    .alu_op     (w_alu_op),
    .passes     (w_passes),
    .carry_init (w_carry_init),
    .wb_acc     (w_wb_acc),
    .wb_out     (w_wb_out),
    .illegal    (w_illegal)
  );

  // Final bit of the final pass: r_pass_cnt has not yet been decremented.
  assign w_last_pass_bit = (r_bit_cnt == LAST_BIT) && (r_pass_cnt <= 4'd1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next_state = ST_LOAD;
      ST_LOAD:  w_next_state = (w_passes != 4'd0) ? ST_SHIFT : ST_WB;
      ST_SHIFT: if (w_last_pass_bit) w_next_state = ST_WB;
      ST_WB:    w_next_state = ST_IDLE;
      default:  w_next_state = ST_IDLE;
    endcase
  end

  // Instruction latch and serial counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_opcode   <= 4'd0;
      r_shamt    <= 4'd0;
      r_operand  <= 8'd0;
      r_bit_cnt  <= '0;
      r_pass_cnt <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_bit_cnt <= '0;
          if (start) begin
            r_opcode  <= opcode;
            r_operand <= instr[11:4];
            r_shamt   <= instr[3:0];
          end
        end
        ST_LOAD: begin
          r_bit_cnt  <= '0;
          r_pass_cnt <= w_passes;
        end
        ST_SHIFT: begin
          // Passes run back to back: bit_idx wraps straight to 0.
          if (r_bit_cnt == LAST_BIT) begin
            r_bit_cnt  <= '0;
            r_pass_cnt <= r_pass_cnt - 4'd1;
          end else begin
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        default: r_bit_cnt <= '0;
      endcase
    end
  end

  // Any start outside IDLE (including the WB cycle) is dropped and flagged.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overrun <= 1'b0;
    end else if (start && (r_state != ST_IDLE)) begin
      r_overrun <= 1'b1;
    end
  end

  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_WB);
  assign op_load    = (r_state == ST_LOAD);
  assign shift_en   = (r_state == ST_SHIFT);
  assign operand    = r_operand;
  assign bit_idx    = r_bit_cnt;
  assign first_bit  = shift_en && (r_bit_cnt == '0);
  assign last_bit   = shift_en && (r_bit_cnt == LAST_BIT);
  // ALU controls are held quiet while idle so nothing downstream sees a
  // stale function from the previous instruction.
  assign carry_init = busy && w_carry_init;
  assign alu_op     = busy ? w_alu_op : 3'd0;
  assign acc_we     = done && w_wb_acc;
  assign out_we     = done && w_wb_out;
  assign illegal    = done && w_illegal;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_bitserial_exec_ctrl.sv
// Scoreboard bench for bitserial_exec_ctrl: the driver queues the expected
// writeback record when it issues an instruction; the monitor gathers per-
// instruction strobe statistics and checks them on each done pulse.
module tb_bitserial_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  opcode;
  logic [11:0] instr;
  logic        busy, done, op_load, shift_en, first_bit, last_bit;
  logic        carry_init, acc_we, out_we, illegal, overrun;
  logic [7:0]  operand;
  logic [2:0]  bit_idx;
  logic [2:0]  alu_op;

  bitserial_exec_ctrl #(.WIDTH(8), .CNT_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .opcode     (opcode),
    .instr      (instr),
    .busy       (busy),
    .done       (done),
    .op_load    (op_load),
    .operand    (operand),
    .shift_en   (shift_en),
    .bit_idx    (bit_idx),
    .first_bit  (first_bit),
    .last_bit   (last_bit),
    .carry_init (carry_init),
    .alu_op     (alu_op),
    .acc_we     (acc_we),
    .out_we     (out_we),
    .illegal    (illegal),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [11:0] ins;
    int         lat;     // negedge samples from start-seen to done
    bit         acc;
    bit         out;
    bit         ill;
    logic [7:0] operand;
    logic [2:0] alu;
    bit         ci;
    int         passes;
  } exp_t;

  exp_t q[$];
  int   compared = 0;
  int   mismatched = 0;
  int   stray = 0;

  task automatic chk(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  function automatic exp_t mk(input string nm, input logic [3:0] op, input logic [11:0] ins,
                              input int lat, input bit acc, input bit out, input bit ill,
                              input logic [7:0] opnd, input logic [2:0] alu, input bit ci,
                              input int passes);
    exp_t e;
    e.name = nm; e.op = op; e.ins = ins; e.lat = lat; e.acc = acc; e.out = out;
    e.ill = ill; e.operand = opnd; e.alu = alu; e.ci = ci; e.passes = passes;
    return e;
  endfunction

  // ---------------- monitor ----------------
  int ncyc = 0;
  int issue_cyc = 0;
  bit tracking = 0;
  bit idle_chk = 0;
  int n_load, n_shift, n_first, n_last, bad_idx, bad_ctl;

  always @(negedge clk) begin
    ncyc++;
    if (!done && (acc_we || out_we || illegal)) stray++;
    if (!rst_n) begin
      tracking = 0;
      idle_chk = 0;
    end else begin
      if (idle_chk) begin
        chk("busy_low_after_done", int'(busy), 0);
        idle_chk = 0;
      end
      if (start && !busy) begin
        tracking = 1; issue_cyc = ncyc;
        n_load = 0; n_shift = 0; n_first = 0; n_last = 0; bad_idx = 0; bad_ctl = 0;
      end else if (tracking && busy) begin
        int e_idx;
        e_idx = n_shift % 8;
        if (op_load) n_load++;
        if (shift_en) begin
          if (int'(bit_idx) != e_idx) bad_idx++;
          if (first_bit != (e_idx == 0)) bad_idx++;
          if (last_bit != (e_idx == 7)) bad_idx++;
          n_first += int'(first_bit);
          n_last  += int'(last_bit);
          n_shift++;
        end else if (first_bit || last_bit) begin
          bad_idx++;
        end
        if (q.size() > 0)
          if (alu_op != q[0].alu || carry_init != q[0].ci || operand != q[0].operand) bad_ctl++;
      end
      if (done) begin
        if (q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk($sformatf("%s latency", e.name), tracking ? ncyc - issue_cyc : -1, e.lat);
          chk($sformatf("%s acc_we", e.name), int'(acc_we), int'(e.acc));
          chk($sformatf("%s out_we", e.name), int'(out_we), int'(e.out));
          chk($sformatf("%s illegal", e.name), int'(illegal), int'(e.ill));
          chk($sformatf("%s op_load_count", e.name), n_load, 1);
          chk($sformatf("%s shift_count", e.name), n_shift, 8 * e.passes);
          chk($sformatf("%s first_bit_count", e.name), n_first, e.passes);
          chk($sformatf("%s last_bit_count", e.name), n_last, e.passes);
          chk($sformatf("%s bit_idx_errors", e.name), bad_idx, 0);
          chk($sformatf("%s ctl_unstable", e.name), bad_ctl, 0);
          $display("txn %s op=%h instr=%h done after %0d cycles", e.name, e.op, e.ins,
                   ncyc - issue_cyc);
        end
        tracking = 0;
        idle_chk = 1;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [3:0] op, input logic [11:0] ins, input exp_t e, input bit push);
    @(posedge clk); #2;
    if (push) q.push_back(e);
    opcode = op; instr = ins; start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    // Scramble the inputs: the DUT must run from its latched copy.
    opcode = ~op; instr = ~ins;
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (busy && k < 200) begin
      @(posedge clk); #2;
      k++;
    end
    if (k >= 200) chk("busy_timeout", int'(busy), 0);
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  exp_t vecs[10];
  exp_t e_add;

  initial begin
    rst_n = 1'b0; start = 1'b0; opcode = 4'h0; instr = 12'h000;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outputs", int'({busy, done, op_load, operand, shift_en, bit_idx, first_bit,
                                last_bit, carry_init, alu_op, acc_we, out_we, illegal, overrun}), 0);
    end

    //            name     op    instr   lat acc out ill opnd   alu  ci passes
    vecs[0] = mk("ADD",   4'h1, 12'h2A0, 10, 1, 0, 0, 8'h2A, 3'd0, 0, 1);
    vecs[1] = mk("SUB",   4'h2, 12'h150, 10, 1, 0, 0, 8'h15, 3'd1, 1, 1);
    vecs[2] = mk("SHL3",  4'h7, 12'h813, 26, 1, 0, 0, 8'h81, 3'd6, 0, 3);
    vecs[3] = mk("SHL0",  4'h7, 12'h7F0,  2, 1, 0, 0, 8'h7F, 3'd6, 0, 0);
    vecs[4] = mk("OUT",   4'h9, 12'h000,  2, 0, 1, 0, 8'h00, 3'd0, 0, 0);
    vecs[5] = mk("ILLC",  4'hC, 12'h555,  2, 0, 0, 1, 8'h55, 3'd0, 0, 0);
    vecs[6] = mk("LDI",   4'h6, 12'hFF0, 10, 1, 0, 0, 8'hFF, 3'd5, 0, 1);
    vecs[7] = mk("SHR9",  4'h8, 12'h019, 74, 1, 0, 0, 8'h01, 3'd7, 0, 9);
    vecs[8] = mk("XOR",   4'h5, 12'hA5F, 10, 1, 0, 0, 8'hA5, 3'd4, 0, 1);
    vecs[9] = mk("NOP",   4'h0, 12'h123,  2, 0, 0, 0, 8'h12, 3'd0, 0, 0);

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].ins, vecs[i], 1'b1);
      wait_idle();
    end
    chk("overrun_clear_before", int'(overrun), 0);

    // start during SHIFT (sampled at N+5)
    e_add = mk("ADD_ovr5", 4'h1, 12'h2A0, 10, 1, 0, 0, 8'h2A, 3'd0, 0, 1);
    issue(4'h1, 12'h2A0, e_add, 1'b1);
    repeat (4) @(posedge clk);
    #2 start = 1'b1; opcode = 4'h5; instr = 12'h333;
    @(posedge clk); #2 start = 1'b0;
    wait_idle();
    chk("overrun_set_shift", int'(overrun), 1);
    repeat (5) @(posedge clk);
    #2 chk("overrun_sticky", int'(overrun), 1);
    do_reset();
    #1 chk("overrun_cleared", int'(overrun), 0);

    // start in the WB cycle (sampled at N+10)
    e_add = mk("ADD_ovrwb", 4'h1, 12'h3C0, 10, 1, 0, 0, 8'h3C, 3'd0, 0, 1);
    issue(4'h1, 12'h3C0, e_add, 1'b1);
    repeat (9) @(posedge clk);
    #2 start = 1'b1; opcode = 4'h2; instr = 12'h444;
    @(posedge clk); #2 start = 1'b0;
    repeat (3) @(posedge clk);
    #2 chk("no_restart_after_wb_start", int'(busy), 0);
    chk("overrun_set_wb", int'(overrun), 1);
    do_reset();

    // reset mid-instruction (sampled at N+6): no done expected
    issue(4'h1, 12'h2A0, e_add, 1'b0);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    @(posedge clk); #2;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_shift_en", int'(shift_en), 0);
    chk("abort_bit_idx", int'(bit_idx), 0);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);

    // recovery after abort
    issue(vecs[1].op, vecs[1].ins, vecs[1], 1'b1);
    wait_idle();

    repeat (5) @(posedge clk);
    #2;
    chk("queue_empty", q.size(), 0);
    chk("stray_write_enables", stray, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
